// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB write per entry; FFF0 settles, FFFF ends.
// Optional SCCB ready timeout is built only when CONFIG_TIMEOUT_EN is defined.
module ov7670_config_sequencer #(
    parameter int unsigned DELAY_CYCLES   = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic [7:0]  rom_addr_o,
    input  logic [15:0] rom_dout_i,
    input  logic        sccb_ready_i,
    output logic        sccb_start_o,
    output logic [7:0]  sccb_addr_o,
    output logic [7:0]  sccb_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StHold,
        StWaitAck,
        StDelay,
        StNext,
        StFinish
    } state_e;

    localparam logic [15:0] EntryEnd   = 16'hFFFF;
    localparam logic [15:0] EntryDelay = 16'hFFF0;
    localparam logic [31:0] DelayLast  = 32'(DELAY_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  rom_addr_q;
    logic        sccb_start_q;
    logic [7:0]  sccb_addr_q;
    logic [7:0]  sccb_data_q;
    logic        busy_q;
    logic        done_q;
    // Shared by the ROM fetch wait and the settle delay; the two never overlap.
    logic [31:0] cnt_q;

`ifdef CONFIG_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt_q;
    logic        error_q;
    assign error_o = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign error_o        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rom_addr_q   <= '0;
            sccb_start_q <= 1'b0;
            sccb_addr_q  <= '0;
            sccb_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
`ifdef CONFIG_TIMEOUT_EN
            to_cnt_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            sccb_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        cnt_q      <= '0;
`ifdef CONFIG_TIMEOUT_EN
                        error_q    <= 1'b0;
`endif
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    if (cnt_q == 32'd1) begin
                        state_q <= StDecode;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StDecode: begin
                    if (rom_dout_i == EntryEnd) begin
                        state_q <= StFinish;
                    end else if (rom_dout_i == EntryDelay) begin
                        cnt_q   <= '0;
                        state_q <= StDelay;
                    end else begin
                        sccb_addr_q <= rom_dout_i[15:8];
                        sccb_data_q <= rom_dout_i[7:0];
`ifdef CONFIG_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (sccb_ready_i) begin
                        sccb_start_q <= 1'b1;
                        state_q      <= StHold;
                    end
`ifdef CONFIG_TIMEOUT_EN
                    else if (to_cnt_q == TimeoutLast) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
`endif
                end
                StHold: begin
                    // The master drops ready in response to the pulse, so it is not sampled here.
`ifdef CONFIG_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (sccb_ready_i) begin
                        state_q <= StNext;
                    end
`ifdef CONFIG_TIMEOUT_EN
                    else if (to_cnt_q == TimeoutLast) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
`endif
                end
                StDelay: begin
                    if (cnt_q == DelayLast) begin
                        state_q <= StNext;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StNext: begin
                    if (rom_addr_q == 8'hFF) begin
                        state_q <= StFinish;
                    end else begin
                        rom_addr_q <= rom_addr_q + 8'd1;
                        cnt_q      <= '0;
                        state_q    <= StFetch;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rom_addr_o   = rom_addr_q;
    assign sccb_start_o = sccb_start_q;
    assign sccb_addr_o  = sccb_addr_q;
    assign sccb_data_o  = sccb_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: registered ROM model, SCCB master model and a
// list-level reference model of the write sequence and its cycle cost.
module tb_ov7670_config_sequencer;

    localparam int Delay   = 16;
    localparam int Timeout = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        busy;
    logic        done;
    logic        error;

    ov7670_config_sequencer #(
        .DELAY_CYCLES  (Delay),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .rom_addr_o  (rom_addr),
        .rom_dout_i  (rom_dout),
        .sccb_ready_i(sccb_ready),
        .sccb_start_o(sccb_start),
        .sccb_addr_o (sccb_addr),
        .sccb_data_o (sccb_data),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [256];
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    // Master: ready drops for 'lat' cycles after each accepted request.
    int  lat;
    bit  force_low;
    int  mbusy;
    always @(posedge clk or posedge rst) begin
        if (rst) mbusy <= 0;
        else if (sccb_start) mbusy <= lat;
        else if (mbusy != 0) mbusy <= mbusy - 1;
    end
    assign sccb_ready = !force_low && (mbusy == 0);

    int          cyc;
    logic [15:0] wq[$];
    int          wc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sccb_start === 1'b1) begin
            wq.push_back({sccb_addr, sccb_data});
            wc.push_back(cyc);
        end
    end

    int          pass_cnt;
    int          chk_cnt;
    logic [15:0] exp_q[$];
    int          exp_last;
    int          exp_k;

    // Expected writes, last ROM address and cycle of done, from the entry rules alone.
    task automatic build_expect(input int l);
        int  t;
        bit  term;
        t = 0;
        term = 1'b0;
        exp_last = 255;
        exp_q.delete();
        for (int a = 0; a < 256; a++) begin
            if (rom_mem[a] == 16'hFFFF) begin
                exp_last = a;
                t += 4;
                term = 1'b1;
                break;
            end else if (rom_mem[a] == 16'hFFF0) begin
                t += Delay + 4;
            end else begin
                exp_q.push_back(rom_mem[a]);
                t += l + 7;
            end
        end
        if (!term) t += 1;
        exp_k = t + 1;
    endtask

    task automatic rom_clear();
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 1;
        while (!(done === 1'b1 && busy === 1'b0) && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        force_low = 1'b0;
        lat = 0;
        rom_clear();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({rom_addr, sccb_addr, sccb_data} !== 24'h0) $display("FAIL reset_addr_data: got %h expected 000000", {rom_addr, sccb_addr, sccb_data});
        else pass_cnt++;
        chk_cnt++;
        if ({sccb_start, busy, done, error} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {sccb_start, busy, done, error});
        else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if ({busy, done, sccb_start} !== 3'b0) $display("FAIL idle_after_reset: got %b expected 000", {busy, done, sccb_start});
        else pass_cnt++;
    endtask

    task automatic test_write_delay();
        int k;
        rom_clear();
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'h1210;
        lat = 20;
        build_expect(lat);
        wq.delete();
        wc.delete();
        pulse_start();
        wait_done(1000, k);
        chk_cnt++;
        if (wq.size() != 2) $display("FAIL dir_count: got %0d expected 2", wq.size());
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() < 2 || wq[0] !== 16'h1280 || wq[1] !== 16'h1210) $display("FAIL dir_writes: got %p expected 1280,1210", wq);
        else pass_cnt++;
        chk_cnt++;
        if (wc.size() < 2 || wc[1] - wc[0] != Delay + lat + 11) $display("FAIL dir_gap: got %p expected gap %0d", wc, Delay + lat + 11);
        else pass_cnt++;
        chk_cnt++;
        if ({done, busy, rom_addr} !== {2'b10, 8'd3}) $display("FAIL dir_end: got done=%b busy=%b addr=%0d expected 1 0 3", done, busy, rom_addr);
        else pass_cnt++;
        chk_cnt++;
        if (k != exp_k) $display("FAIL dir_cycles: got %0d expected %0d", k, exp_k);
        else pass_cnt++;
    endtask

    task automatic test_ffff_first();
        int k;
        rom_clear();
        lat = 0;
        wq.delete();
        pulse_start();
        wait_done(50, k);
        chk_cnt++;
        if (k > 5 || done !== 1'b1) $display("FAIL ffff_latency: got %0d done=%b expected <=5 done=1", k, done);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() != 0 || rom_addr !== 8'd0) $display("FAIL ffff_quiet: got writes=%0d addr=%0d expected 0 0", wq.size(), rom_addr);
        else pass_cnt++;
    endtask

    task automatic test_ready_stall();
        int k;
        int pulses;
        int unstable;
        rom_clear();
        rom_mem[0] = 16'h1280;
        lat = 2;
        force_low = 1'b1;
        pulses = 0;
        unstable = 0;
        wq.delete();
        pulse_start();
        for (int i = 2; i <= 101; i++) begin
            @(negedge clk);
            if (sccb_start !== 1'b0) pulses++;
            if (i >= 4 && {sccb_addr, sccb_data} !== 16'h1280) unstable++;
        end
        chk_cnt++;
        if (pulses != 0) $display("FAIL stall_no_start: got %0d expected 0", pulses);
        else pass_cnt++;
        chk_cnt++;
        if (unstable != 0) $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
        else pass_cnt++;
        force_low = 1'b0;
        wait_done(100, k);
        chk_cnt++;
        if (wq.size() != 1 || wq[0] !== 16'h1280 || done !== 1'b1) $display("FAIL stall_release: got %p done=%b expected 1280 done=1", wq, done);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_delay();
        int k;
        rom_clear();
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'h1210;
        lat = 3;
        wq.delete();
        pulse_start();
        k = 0;
        while (!(wq.size() == 1 && rom_addr === 8'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b1 || wq.size() != 1) $display("FAIL rd_in_delay: got busy=%b writes=%0d expected 1 1", busy, wq.size());
        else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({rom_addr, sccb_addr, sccb_data, sccb_start, busy, done, error} !== 28'h0) $display("FAIL rd_reset_vals: got %h expected 0", {rom_addr, sccb_addr, sccb_data, sccb_start, busy, done, error});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wq.delete();
        pulse_start();
        chk_cnt++;
        if ({busy, done, rom_addr} !== {2'b10, 8'd0}) $display("FAIL rd_restart: got busy=%b done=%b addr=%0d expected 1 0 0", busy, done, rom_addr);
        else pass_cnt++;
        wait_done(1000, k);
        chk_cnt++;
        if (wq.size() != 2 || wq[0] !== 16'h1280) $display("FAIL rd_rerun: got %p expected 1280,1210", wq);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int k;
        rom_clear();
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'h1210;
        lat = 20;
        wq.delete();
        pulse_start();
        k = 0;
        while (rom_addr !== 8'd2 && k < 300) begin
            @(negedge clk);
            k++;
        end
        pulse_start();
        chk_cnt++;
        if (rom_addr !== 8'd2 || busy !== 1'b1) $display("FAIL busy_start_ignored: got addr=%0d busy=%b expected 2 1", rom_addr, busy);
        else pass_cnt++;
        wait_done(300, k);
        chk_cnt++;
        if (wq.size() != 2 || done !== 1'b1) $display("FAIL busy_run_end: got writes=%0d done=%b expected 2 1", wq.size(), done);
        else pass_cnt++;
        pulse_start();
        chk_cnt++;
        if ({done, busy, rom_addr} !== {2'b01, 8'd0}) $display("FAIL restart_after_done: got done=%b busy=%b addr=%0d expected 0 1 0", done, busy, rom_addr);
        else pass_cnt++;
        wait_done(300, k);
        chk_cnt++;
        if (wq.size() != 4 || wq[2] !== 16'h1280) $display("FAIL restart_writes: got %p expected 2 more writes from 1280", wq);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int k;
        int n;
        int bad;
        for (int it = 0; it < 8; it++) begin
            rom_clear();
            n = int'($urandom_range(0, 8));
            for (int a = 0; a < n; a++) begin
                if ($urandom_range(0, 3) == 0) rom_mem[a] = 16'hFFF0;
                else rom_mem[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            lat = int'($urandom_range(0, 10));
            build_expect(lat);
            wq.delete();
            pulse_start();
            wait_done(2000, k);
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
            end
            chk_cnt++;
            if (wq.size() != exp_q.size() || bad != 0) $display("FAIL rand_writes[%0d]: got %p expected %p", it, wq, exp_q);
            else pass_cnt++;
            chk_cnt++;
            if (rom_addr !== 8'(exp_last) || k != exp_k) $display("FAIL rand_end[%0d]: got addr=%0d cyc=%0d expected %0d %0d", it, rom_addr, k, exp_last, exp_k);
            else pass_cnt++;
            chk_cnt++;
            if ({done, busy, error} !== 3'b100) $display("FAIL rand_flags[%0d]: got %b expected 100", it, {done, busy, error});
            else pass_cnt++;
        end
    endtask

    task automatic test_last_address();
        int k;
        for (int a = 0; a < 256; a++) rom_mem[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
        lat = 0;
        build_expect(lat);
        wq.delete();
        pulse_start();
        wait_done(4000, k);
        chk_cnt++;
        if (wq.size() != 256 || wq[255] !== exp_q[255]) $display("FAIL full_rom_writes: got %0d expected 256", wq.size());
        else pass_cnt++;
        chk_cnt++;
        if (rom_addr !== 8'd255 || k != exp_k || done !== 1'b1) $display("FAIL full_rom_end: got addr=%0d cyc=%0d done=%b expected 255 %0d 1", rom_addr, k, done, exp_k);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k;
        int moved;
        rom_clear();
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'h1210;
        force_low = 1'b1;
        lat = 0;
        wq.delete();
        pulse_start();
`ifdef CONFIG_TIMEOUT_EN
        k = 1;
        while (error !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk_cnt++;
        if ({error, done, busy} !== 3'b110 || k < Timeout + 2 || k > Timeout + 6) $display("FAIL timeout_flag: got err/done/busy=%b at %0d expected 110 near %0d", {error, done, busy}, k, Timeout + 4);
        else pass_cnt++;
        moved = 0;
        repeat (20) begin
            @(negedge clk);
            if (rom_addr !== 8'd0 || sccb_start !== 1'b0) moved++;
        end
        chk_cnt++;
        if (moved != 0 || wq.size() != 0) $display("FAIL timeout_quiet: got %0d moves %0d writes expected 0 0", moved, wq.size());
        else pass_cnt++;
        force_low = 1'b0;
`else
        moved = 0;
        repeat (200) begin
            @(negedge clk);
            if (error !== 1'b0 || busy !== 1'b1) moved++;
        end
        chk_cnt++;
        if (moved != 0 || wq.size() != 0) $display("FAIL wait_forever: got %0d bad cycles %0d writes expected 0 0", moved, wq.size());
        else pass_cnt++;
        force_low = 1'b0;
        wait_done(200, k);
        chk_cnt++;
        if (wq.size() != 2 || done !== 1'b1) $display("FAIL wait_resume: got writes=%0d done=%b expected 2 1", wq.size(), done);
        else pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt = 0;
        test_reset();
        test_write_delay();
        test_ffff_first();
        test_ready_stall();
        test_reset_in_delay();
        test_start_while_busy();
        test_random();
        test_last_address();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
